imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-memory fetch controller with a two-entry instruction buffer
// and a loader write path sharing the same memory port.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   en              fetch enable from the core
//   imem_addr       memory byte address (loader address in LOAD, pc otherwise)
//   imem_rdata      combinational read data for imem_addr
//   imem_we         memory write strobe (loader writes only)
//   imem_wdata      memory write data
//   ld_valid/ready  loader write handshake, with ld_addr / ld_data
//   redirect_valid  branch/jump redirect, target redirect_pc
//   inst_valid      buffer head valid, with inst / inst_pc
//   inst_ready      decode accepts the head entry
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The source holds its payload stable until that edge. ld_ready
// is only raised in LOAD, so the loader must keep ld_valid and its payload
// up until it sees ld_ready.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [1:0]  FULL     = 2'(BUF_DEPTH);
  localparam logic [31:0] PC_RESET = {RESET_PC[31:2], 2'b00};

  // state / state_nxt are kept as plain named signals so checkers can bind
  // to them hierarchically.
  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [1:0]  count;
  logic [31:0] buf_inst [2];
  logic [31:0] buf_pc   [2];

  logic        enter_load;
  logic        flush;
  logic        push;
  logic        pop;

  // Low target bits are dropped: pc is always word aligned.
  logic        unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. The loader always wins over fetch.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ld_valid)  state_nxt = LOAD;
        else if (en)   state_nxt = FETCH;
      end
      FETCH: begin
        if (ld_valid)  state_nxt = LOAD;
        else if (!en)  state_nxt = IDLE;
      end
      LOAD: begin
        if (!ld_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Buffer control
  // ---------------------------------------------------------------------
  // Entering LOAD invalidates buffered instructions because the loader may
  // overwrite the words they came from. Entering LOAD implies ld_valid=1,
  // so no push can coincide with it.
  assign enter_load = (state != LOAD) && (state_nxt == LOAD);
  assign flush      = redirect_valid || enter_load;
  assign pop        = (count != 2'd0) && inst_ready && !redirect_valid;
  assign push       = (state == FETCH) && en && !ld_valid && !redirect_valid &&
                      ((count != FULL) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= 2'd0;
      buf_inst[0] <= 32'h0;
      buf_inst[1] <= 32'h0;
      buf_pc[0]   <= 32'h0;
      buf_pc[1]   <= 32'h0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) begin
            buf_inst[0] <= imem_rdata;
            buf_pc[0]   <= pc;
          end else begin
            buf_inst[1] <= imem_rdata;
            buf_pc[1]   <= pc;
          end
        end
        2'b01: begin
          count       <= count - 2'd1;
          buf_inst[0] <= buf_inst[1];
          buf_pc[0]   <= buf_pc[1];
        end
        2'b11: begin
          // Count unchanged; the tail moves up and the new word lands behind
          // it, or becomes the head when it was the only entry.
          if (count == FULL) begin
            buf_inst[0] <= buf_inst[1];
            buf_pc[0]   <= buf_pc[1];
            buf_inst[1] <= imem_rdata;
            buf_pc[1]   <= pc;
          end else begin
            buf_inst[0] <= imem_rdata;
            buf_pc[0]   <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_RESET;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    imem_addr  = pc;
    imem_we    = 1'b0;
    imem_wdata = 32'h0;
    ld_ready   = 1'b0;
    if (state == LOAD) begin
      imem_addr  = ld_addr;
      imem_we    = ld_valid;
      imem_wdata = ld_data;
      ld_ready   = ld_valid;
    end
  end

  assign inst_valid = (count != 2'd0);
  assign inst       = inst_valid ? buf_inst[0] : 32'h0;
  assign inst_pc    = inst_valid ? buf_pc[0]   : 32'h0;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
// Self-checking bench for imem_fetch_ctrl. A word-addressed memory model
// answers reads combinationally; loader writes are applied to it at the
// rising edge. Expected {pc, inst} pairs are queued when a scenario starts
// and popped whenever decode accepts the head entry.
//
// Timing: inputs change 1 time unit after a rising edge; outputs are sampled
// at the falling edge (and at +1 for direct checks).
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic [31:0] mem [0:1023];
  logic [63:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          wr_cnt   = 0;

  // -------------------------------------------------------------------
  // Clock / DUT
  // -------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_we        (imem_we),
    .imem_wdata     (imem_wdata),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  assign imem_rdata = mem[imem_addr[11:2]];

  // -------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------
  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0010_0093;
      1:       return 32'h0020_0113;
      2:       return 32'h0030_0193;
      3:       return 32'h0040_0213;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Falling-edge sample: scoreboard pop for an accepted head, and capture of
  // a loader write that the next rising edge will perform.
  logic        wr_pend;
  logic [9:0]  wr_idx;
  logic [31:0] wr_dat;

  task automatic observe();
    logic [63:0] e;
    wr_pend = 1'b0;
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_avail", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("head_pc",   {32'h0, inst_pc}, {32'h0, e[63:32]});
        check("head_inst", {32'h0, inst},    {32'h0, e[31:0]});
      end
    end
    if (imem_we) begin
      wr_pend = 1'b1;
      wr_idx  = imem_addr[11:2];
      wr_dat  = imem_wdata;
    end
  endtask

  // One clock: sample at the falling edge, then advance to rising edge + 1.
  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    if (wr_pend) begin
      mem[wr_idx] = wr_dat;
      wr_cnt++;
    end
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] word);
    exp_q.push_back({pc, word});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    check({tag, "_inst"},       64'(inst),       64'd0);
    check({tag, "_inst_pc"},    64'(inst_pc),    64'd0);
    check({tag, "_imem_we"},    64'(imem_we),    64'd0);
    check({tag, "_ld_ready"},   64'(ld_ready),   64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_imem_addr"},  64'(imem_addr),  64'(RESET_PC));
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    en             = 1'b0;
    ld_valid       = 1'b0;
    ld_addr        = 32'h0;
    ld_data        = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // -------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------
  initial begin
    int   wc;
    logic got;
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    wr_pend = 1'b0;
    wr_idx  = '0;
    wr_dat  = '0;

    // Straight-line fetch: one instruction per cycle, no bubbles.
    do_reset();
    en = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 7; i++) push_exp(32'(i * 4), init_word(i));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) en = 1'b0;
      #1;
      if (i >= 2) check("line_no_bubble", 64'(inst_valid), 64'd1);
      step();
    end
    #1;
    check("line_drained", 64'(inst_valid), 64'd0);
    check("line_sb_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: buffer saturates, pc freezes at 8, order kept.
    do_reset();
    en = 1'b1;
    inst_ready = 1'b0;
    push_exp(32'h0, init_word(0));
    push_exp(32'h4, init_word(1));
    push_exp(32'h8, init_word(2));
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i >= 3) begin
        check("bp_addr_frozen", 64'(imem_addr), 64'h8);
        check("bp_head_held",   64'(inst_pc),   64'h0);
      end
      step();
    end
    inst_ready = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #1;
    check("bp_drained", 64'(inst_valid), 64'd0);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Redirect while full: flush, aligned target, refetch from target.
    do_reset();
    en = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #1;
    check("rd_full_addr", 64'(imem_addr), 64'h8);
    check("rd_full_valid", 64'(inst_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0013;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #1;
    check("rd_flushed", 64'(inst_valid), 64'd0);
    check("rd_pc", 64'(imem_addr), 64'h10);
    push_exp(32'h10, init_word(4));
    step();
    en = 1'b0;
    #1;
    check("rd_target_pc", 64'(inst_pc), 64'h10);
    step();
    #1;
    check("rd_drained", 64'(inst_valid), 64'd0);
    check("rd_sb_empty", 64'(exp_q.size()), 64'd0);

    // Loader preemption during FETCH: 3 writes, flush, resume at pc=4.
    do_reset();
    en = 1'b1;
    inst_ready = 1'b0;
    step();
    step();
    wc = wr_cnt;
    for (int w = 0; w < 3; w++) begin
      ld_valid = 1'b1;
      ld_addr  = 32'(w * 4);
      ld_data  = 32'hDEAD_0000 + 32'(w);
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
        #1;
        if (ld_ready) begin
          got = 1'b1;
          check("ld_we",    64'(imem_we),    64'd1);
          check("ld_addr",  64'(imem_addr),  64'(w * 4));
          check("ld_wdata", 64'(imem_wdata), 64'(32'hDEAD_0000 + 32'(w)));
          check("ld_flushed", 64'(inst_valid), 64'd0);
        end
        step();
      end
      check("ld_accepted", 64'(got), 64'd1);
    end
    ld_valid = 1'b0;
    en = 1'b0;
    #1;
    check("ld_idle_ready", 64'(ld_ready), 64'd0);
    check("ld_idle_we",    64'(imem_we),  64'd0);
    step();
    check("ld_wr_count", 64'(wr_cnt - wc), 64'd3);
    en = 1'b1;
    inst_ready = 1'b1;
    push_exp(32'h4, 32'hDEAD_0001);
    push_exp(32'h8, 32'hDEAD_0002);
    push_exp(32'hC, init_word(3));
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    for (int i = 0; i < 2; i++) step();
    #1;
    check("ld_resume_drained", 64'(inst_valid), 64'd0);
    check("ld_sb_empty", 64'(exp_q.size()), 64'd0);

    // Async reset in the middle of a load, off a clock edge.
    ld_valid = 1'b1;
    ld_addr  = 32'h20;
    ld_data  = 32'hCAFE_F00D;
    step();
    check("ar_in_load", 64'(imem_we), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("ar");
    wc = wr_cnt;
    @(negedge clk);
    check("ar_no_we", 64'(imem_we), 64'd0);
    @(posedge clk);
    #1;
    check("ar_wr_count", 64'(wr_cnt - wc), 64'd0);
    check("ar_mem_kept", 64'(mem[8]), 64'(init_word(8)));
    #2;
    rst      = 1'b0;
    ld_valid = 1'b0;
    en       = 1'b1;
    inst_ready = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (inst_valid) got = 1'b1;
    end
    check("ar_first_valid", 64'(got), 64'd1);
    check("ar_first_pc",   64'(inst_pc), 64'(RESET_PC));
    check("ar_first_inst", 64'(inst),    64'(32'hDEAD_0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
